seq_tx_10001: RTL and testbench
===============================

# seq_tx_10001

Serial pattern transmitter for the sequence-detector family: on a start request it emits a programmable number of back-to-back frames of the 5-bit pattern 10001, MSB first, one bit per clock, with optional idle gap bits between frames. It is the driving end of the serial `in` line consumed by the Moore 10001 detector. It serves as a bench stimulus source and as an on-chip pattern/BIST generator.

## Interface
- `PATTERN`, 5'b10001: frame bits, transmitted bit 4 first.
- `GAP`, 2: idle cycles (`out`=0) inserted between consecutive frames; 0 allowed.
- `CW`, 4: width of frame count.

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  transmit request; sampled only in IDLE.
- `count`  in  CW  number of frames; captured when start is accepted.
- `out`  out  1  serial data bit.
- `valid`  out  1  high while `out` carries a pattern bit.
- `busy`  out  1  high from first bit through DONE cycle.
- `done`  out  1  one-cycle pulse after final bit.

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: start=1 and count!=0 -> SEND, bit index=0, frames_left=count; start=1 with count=0 ignored, stay IDLE.
- SEND: out=PATTERN[4-bit_idx], valid=1. bit_idx 0..4; at bit_idx=4: frames_left>1 -> GAP (or SEND with bit_idx=0 if GAP=0), decrement frames_left; frames_left=1 -> DONE.
- GAP: out=0, valid=0, gap counter runs GAP cycles, then SEND, bit_idx=0.
- DONE: done=1, busy=1, out=0, valid=0; unconditionally -> IDLE.
- Moore outputs: `out`, `valid`, `busy`, `done` decode from registered state/counters only; no combinational path from `start`.
- `start` in SEND/GAP/DONE ignored, no queuing; `count` changes after acceptance have no effect.
- Reset values (also on reset mid-frame): state=IDLE, out=0, valid=0, busy=0, done=0, all counters 0; partial frame abandoned, no done pulse.

## Timing
- Start accepted at edge k -> first pattern bit on `out` in cycle k+1 (latency 1).
- Frame occupies 5 cycles; N frames finish at cycle k+5N+GAP*(N-1); done pulses in cycle k+5N+GAP*(N-1)+1.
- No gap after last frame.
- Earliest next accepted start: edge ending the first IDLE cycle after DONE (minimum 1 idle cycle between bursts).
- GAP=0: frames concatenate (1000110001...), each counted once by a non-overlapping detector.
- count=max (2^CW-1) must complete without wrap.

## Configuration
- `SEQ_TX_ERR_INJECT_EN` defined: extra input `inject_err` (1 bit), captured with the accepted start; when 1, the final bit of the last frame is inverted (frame reads 10000), all timing unchanged.
- Undefined: port absent, every frame is exactly PATTERN.

## Structure
- Shared package `seq_pkg`: state enum typedef (IDLE, SEND, GAP, DONE), constant PLEN=5, default pattern constant 5'b10001.
- One natural sub-module: `seq_frame_cnt`, a CW-bit loadable down-counter (load, dec, is_one) for frames_left; bit and gap counters stay inline.

## Test plan
- Reset asserted mid-SEND at bit 2 -> same cycle out=0, valid=0, busy=0; after release no done pulse, IDLE.
- start=1, count=1, GAP=2 at edge k -> out 1,0,0,0,1 in cycles k+1..k+5, valid=1 there, done=1 at k+6 only.
- count=3, GAP=2 -> 10001 00 10001 00 10001, done at k+20; detector reports exactly 3 hits.
- count=0 with start=1 -> busy stays 0, no output activity; start pulsed during busy -> burst length unchanged.
- GAP=0, count=2 -> 1000110001 contiguous, valid high 10 cycles, done at k+11.
- With SEQ_TX_ERR_INJECT_EN, inject_err=1, count=2 -> 10001 then 10000; detector reports 1 hit; done timing identical.

Source files
------------

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the 10001 sequence-detector family: the transmitter
// state encoding, the frame length and the default frame pattern.
// No ports (package).
// ---------------------------------------------------------------------------
package seq_pkg;

   localparam int PLEN = 5;

   localparam logic [PLEN-1:0] DEFAULT_PATTERN = 5'b10001;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } seq_state_e;

endpackage

// File: rtl/seq_frame_cnt.sv
// ---------------------------------------------------------------------------
// seq_frame_cnt
// Loadable down-counter holding the number of frames still to be sent in the
// current burst. It saturates at zero, and load has priority over dec.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset (value cleared to 0)
//   load     in   load load_val on the next edge
//   dec      in   decrement on the next edge (ignored while load is high)
//   load_val in   CW-bit value to load
//   is_one   out  counter currently holds exactly 1 (last frame in flight)
// ---------------------------------------------------------------------------
module seq_frame_cnt #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          dec,
   input  logic [CW-1:0] load_val,
   output logic          is_one
);

   logic [CW-1:0] value_q;
   logic [CW-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (dec && (value_q != '0)) begin
         value_d = value_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign is_one = (value_q == CW'(1));

endmodule

// File: rtl/seq_tx_10001.sv
// ---------------------------------------------------------------------------
// seq_tx_10001
// Serial pattern transmitter. A start request with a non-zero count sends that
// many frames of PATTERN, MSB first, one bit per clock, with GAP idle zero
// bits between consecutive frames, followed by a one-cycle DONE state.
//
// Parameters:
//   PATTERN  frame bits, transmitted bit PLEN-1 first
//   GAP      idle cycles between frames (0 = back-to-back frames)
//   CW       width of the frame count
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   start       in   transmit request, sampled only while idle
//   count       in   number of frames, captured with an accepted start
//   inject_err  in   only when SEQ_TX_ERR_INJECT_EN is defined: captured with
//                    an accepted start; inverts the final bit of the last frame
//   out         out  serial data bit
//   valid       out  out carries a pattern bit
//   busy        out  high from the first bit through the DONE cycle
//   done        out  one-cycle pulse after the final bit
//
// Build option: define SEQ_TX_ERR_INJECT_EN to add the inject_err port.
// ---------------------------------------------------------------------------
module seq_tx_10001
   import seq_pkg::*;
#(
   parameter logic [PLEN-1:0] PATTERN = DEFAULT_PATTERN,
   parameter int              GAP     = 2,
   parameter int              CW      = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] count,
`ifdef SEQ_TX_ERR_INJECT_EN
   input  logic          inject_err,
`endif
   output logic          out,
   output logic          valid,
   output logic          busy,
   output logic          done
);

   // One bit is enough when GAP <= 2; with GAP = 0 the gap state is unreachable.
   localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;
   localparam logic [2:0] LAST_BIT = 3'(PLEN - 1);

   seq_state_e    state_q, state_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic          frame_load;
   logic          frame_dec;
   logic          frame_is_one;
   logic          pat_bit;

   seq_frame_cnt #(
      .CW (CW)
   ) u_frame_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (frame_load),
      .dec      (frame_dec),
      .load_val (count),
      .is_one   (frame_is_one)
   );

   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      gap_cnt_d  = gap_cnt_q;
      frame_load = 1'b0;
      frame_dec  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && (count != '0)) begin
               state_d    = S_SEND;
               bit_idx_d  = '0;
               frame_load = 1'b1;
            end
         end
         S_SEND: begin
            if (bit_idx_q == LAST_BIT) begin
               bit_idx_d = '0;
               if (frame_is_one) begin
                  state_d = S_DONE;
               end else begin
                  frame_dec = 1'b1;
                  if (GAP == 0) begin
                     state_d = S_SEND;
                  end else begin
                     state_d   = S_GAP;
                     gap_cnt_d = '0;
                  end
               end
            end else begin
               bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GW'(GAP - 1)) begin
               state_d   = S_SEND;
               bit_idx_d = '0;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef SEQ_TX_ERR_INJECT_EN
   logic inject_q;
   logic inject_d;

   always_comb begin
      inject_d = inject_q;
      if (frame_load) begin
         inject_d = inject_err;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         bit_idx_q <= '0;
         gap_cnt_q <= '0;
`ifdef SEQ_TX_ERR_INJECT_EN
         inject_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         gap_cnt_q <= gap_cnt_d;
`ifdef SEQ_TX_ERR_INJECT_EN
         inject_q  <= inject_d;
`endif
      end
   end

   // Pattern bit for the current index; bit_idx_q only reaches LAST_BIT, so
   // the index never leaves the pattern range.
   always_comb begin
      pat_bit = PATTERN[LAST_BIT - bit_idx_q];
`ifdef SEQ_TX_ERR_INJECT_EN
      if (inject_q && frame_is_one && (bit_idx_q == LAST_BIT)) begin
         pat_bit = ~pat_bit;
      end
`endif
   end

   // Moore decode: every output depends only on registered state.
   assign valid = (state_q == S_SEND);
   assign out   = valid & pat_bit;
   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_tx_10001.sv
// ---------------------------------------------------------------------------
// tb_seq_tx_10001
// Self-checking bench for seq_tx_10001. Two instances share the stimulus: one
// with GAP=2 and one with GAP=0. Expected outputs come from an arithmetic
// model of the burst timeline.
// ---------------------------------------------------------------------------
module tb_seq_tx_10001;
   import seq_pkg::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] count = '0;
`ifdef SEQ_TX_ERR_INJECT_EN
   logic          inject_err = 1'b0;
`endif
   logic out2, valid2, busy2, done2;
   logic out0, valid0, busy0, done0;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   seq_tx_10001 #(.PATTERN(DEFAULT_PATTERN), .GAP(2), .CW(CW)) dut_gap2 (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .count      (count),
`ifdef SEQ_TX_ERR_INJECT_EN
      .inject_err (inject_err),
`endif
      .out        (out2),
      .valid      (valid2),
      .busy       (busy2),
      .done       (done2)
   );

   seq_tx_10001 #(.PATTERN(DEFAULT_PATTERN), .GAP(0), .CW(CW)) dut_gap0 (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .count      (count),
`ifdef SEQ_TX_ERR_INJECT_EN
      .inject_err (inject_err),
`endif
      .out        (out0),
      .valid      (valid0),
      .busy       (busy0),
      .done       (done0)
   );

   typedef struct packed {
      logic out;
      logic valid;
      logic busy;
      logic done;
   } obs_t;

   typedef struct {
      int unsigned n;
      bit          inj;
      bit          poke;
      int          exp_done2;
      int          exp_valid2;
      int          exp_hits2;
      int          exp_done0;
   } vec_t;

   // Expected outputs i cycles after the accepting edge, from the burst rules:
   // n frames of PLEN bits, gap zeros between frames, then one done cycle.
   function automatic obs_t model(int n, int gap, bit inj, int i);
      obs_t            r;
      int              total;
      int              pos;
      int              frame;
      logic [PLEN-1:0] pat;
      r   = '0;
      pat = DEFAULT_PATTERN;
      if (n == 0) return r;
      total = PLEN * n + gap * (n - 1);
      if (i >= 1 && i <= total) begin
         r.busy = 1'b1;
         pos    = (i - 1) % (PLEN + gap);
         frame  = (i - 1) / (PLEN + gap);
         if (pos < PLEN) begin
            r.valid = 1'b1;
            r.out   = pat[PLEN-1-pos];
            if (inj && frame == n - 1 && pos == PLEN - 1) r.out = ~r.out;
         end
      end else if (i == total + 1) begin
         r.busy = 1'b1;
         r.done = 1'b1;
      end
      return r;
   endfunction

   task automatic check_obs(input string name, input int cyc, input obs_t act, input obs_t exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s cycle %0d: got out=%0b valid=%0b busy=%0b done=%0b, expected out=%0b valid=%0b busy=%0b done=%0b",
                  name, cyc, act.out, act.valid, act.busy, act.done,
                  exp.out, exp.valid, exp.busy, exp.done);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Runs one burst request and compares both instances every cycle. Also
   // reports the done offsets, valid count and non-overlapping 10001 hits.
   task automatic apply_stimulus(input int n, input bit inj, input bit poke,
                                 output int done2_at, output int done0_at,
                                 output int valid2_cnt, output int hits2);
      int              win;
      int              d0;
      bit              inj_eff;
      logic [PLEN-1:0] sh;
      obs_t            a2, a0;
`ifdef SEQ_TX_ERR_INJECT_EN
      inj_eff = inj;
`else
      inj_eff = 1'b0;
`endif
      done2_at   = 0;
      done0_at   = 0;
      valid2_cnt = 0;
      hits2      = 0;
      sh         = '0;
      win = (n == 0) ? 3 : (PLEN * n + 2 * (n - 1) + 3);
      d0  = (n == 0) ? 0 : (PLEN * n + 1);

      @(negedge clk);
      start = 1'b1;
      count = CW'(n);
`ifdef SEQ_TX_ERR_INJECT_EN
      inject_err = inj;
`endif
      @(posedge clk);
      #1;
      start = 1'b0;
      count = CW'($urandom);
`ifdef SEQ_TX_ERR_INJECT_EN
      inject_err = 1'($urandom_range(0, 1));
`endif
      for (int i = 1; i <= win; i++) begin
         @(negedge clk);
         a2 = '{out: out2, valid: valid2, busy: busy2, done: done2};
         a0 = '{out: out0, valid: valid0, busy: busy0, done: done0};
         check_obs("gap2_stream", i, a2, model(n, 2, inj_eff, i));
         check_obs("gap0_stream", i, a0, model(n, 0, inj_eff, i));
         if (done2 && done2_at == 0) done2_at = i;
         if (done0 && done0_at == 0) done0_at = i;
         if (valid2) valid2_cnt++;
         sh = {sh[PLEN-2:0], out2};
         if (sh == DEFAULT_PATTERN) begin
            hits2++;
            sh = '0;
         end
         if (poke && i < d0) begin
            start = 1'($urandom_range(0, 1));
            count = CW'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      vec_t vecs[$];
      int   d2, d0, v2, h2;
      obs_t a2, a0;

      vecs.push_back('{n: 1,  inj: 0, poke: 0, exp_done2: 6,   exp_valid2: 5,  exp_hits2: 1,  exp_done0: 6});
      vecs.push_back('{n: 3,  inj: 0, poke: 0, exp_done2: 20,  exp_valid2: 15, exp_hits2: 3,  exp_done0: 16});
      vecs.push_back('{n: 0,  inj: 0, poke: 0, exp_done2: 0,   exp_valid2: 0,  exp_hits2: 0,  exp_done0: 0});
      vecs.push_back('{n: 2,  inj: 0, poke: 1, exp_done2: 13,  exp_valid2: 10, exp_hits2: 2,  exp_done0: 11});
      vecs.push_back('{n: 15, inj: 0, poke: 0, exp_done2: 104, exp_valid2: 75, exp_hits2: 15, exp_done0: 76});
      vecs.push_back('{n: 5,  inj: 0, poke: 1, exp_done2: 34,  exp_valid2: 25, exp_hits2: 5,  exp_done0: 26});
`ifdef SEQ_TX_ERR_INJECT_EN
      vecs.push_back('{n: 2,  inj: 1, poke: 0, exp_done2: 13,  exp_valid2: 10, exp_hits2: 1,  exp_done0: 11});
`endif

      // Reset state while rst is held low.
      repeat (2) @(negedge clk);
      a2 = '{out: out2, valid: valid2, busy: busy2, done: done2};
      a0 = '{out: out0, valid: valid0, busy: busy0, done: done0};
      check_obs("reset_gap2", 0, a2, obs_t'('0));
      check_obs("reset_gap0", 0, a0, obs_t'('0));
      rst = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[v]) begin
         apply_stimulus(int'(vecs[v].n), vecs[v].inj, vecs[v].poke, d2, d0, v2, h2);
         check_int($sformatf("vec%0d_done_gap2", v), d2, vecs[v].exp_done2);
         check_int($sformatf("vec%0d_done_gap0", v), d0, vecs[v].exp_done0);
         check_int($sformatf("vec%0d_valid_gap2", v), v2, vecs[v].exp_valid2);
         check_int($sformatf("vec%0d_hits_gap2", v), h2, vecs[v].exp_hits2);
      end

      // Reset asserted while the GAP=2 instance sends bit 2 of the first frame.
      @(negedge clk);
      start = 1'b1;
      count = CW'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      a2 = '{out: out2, valid: valid2, busy: busy2, done: done2};
      a0 = '{out: out0, valid: valid0, busy: busy0, done: done0};
      check_obs("midframe_reset_gap2", 0, a2, obs_t'('0));
      check_obs("midframe_reset_gap0", 0, a0, obs_t'('0));
      @(negedge clk);
      rst = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         a2 = '{out: out2, valid: valid2, busy: busy2, done: done2};
         a0 = '{out: out0, valid: valid0, busy: busy0, done: done0};
         check_obs("post_reset_idle_gap2", i, a2, obs_t'('0));
         check_obs("post_reset_idle_gap0", i, a0, obs_t'('0));
      end

      // Randomised bursts against the model.
      for (int r = 0; r < 8; r++) begin
         apply_stimulus(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), d2, d0, v2, h2);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
